// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and RAM bus bundle for the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          cpu_req_r;
    logic          cpu_req_w;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;

    logic          mem_r;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req_r, cpu_req_w, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_r, mem_w, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req_r, cpu_req_w, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_r, mem_w, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data RAM arbiter with bounded DMA wait
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arbiter_if.slave bus,
    output logic [15:0] conflict_cnt
);
    localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    logic [AGE_W-1:0] age_cnt;
    logic             resp_valid;
    port_t            resp_port;
    logic             cpu_req;
    logic             both_req;
    logic             dma_wins;
    logic             grant_cpu;
    logic             grant_dma;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_r;
    logic             sel_w;

    assign cpu_req  = bus.cpu_req_r | bus.cpu_req_w;
    assign both_req = cpu_req & bus.dma_req;
    // age_cnt saturates at MAX_WAIT, so equality is the ">=" test
    assign dma_wins = (MAX_WAIT == 0) || (age_cnt == AGE_MAX);

    // Grants are forced low during reset so nothing reaches the RAM
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (!rst) begin
            if (both_req) begin
                grant_dma = dma_wins;
                grant_cpu = ~dma_wins;
            end else begin
                grant_cpu = cpu_req;
                grant_dma = bus.dma_req;
            end
        end
    end

    always_comb begin
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        sel_r     = 1'b0;
        sel_w     = 1'b0;
        if (grant_dma) begin
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
            sel_w     = bus.dma_we;
            sel_r     = ~bus.dma_we;
        end else if (grant_cpu) begin
            // a simultaneous load+store is treated as a store
            sel_w = bus.cpu_req_w;
            sel_r = bus.cpu_req_r & ~bus.cpu_req_w;
        end
    end

    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_r     = sel_r;
    assign bus.mem_w     = sel_w;
    assign bus.cpu_stall = cpu_req & ~grant_cpu & ~rst;
    assign bus.dma_gnt   = grant_dma;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_cnt      <= '0;
            resp_valid   <= 1'b0;
            resp_port    <= PORT_CPU;
            conflict_cnt <= 16'h0000;
        end else begin
            if (bus.dma_req && !grant_dma) begin
                if (age_cnt != AGE_MAX) age_cnt <= age_cnt + AGE_W'(1);
            end else begin
                age_cnt <= '0;
            end
            resp_valid <= sel_r;
            resp_port  <= grant_dma ? PORT_DMA : PORT_CPU;
            if (both_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h0001;
        end
    end

    assign bus.cpu_rvalid = resp_valid && (resp_port == PORT_CPU);
    assign bus.dma_rvalid = resp_valid && (resp_port == PORT_DMA);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] conf4;
    logic [15:0] conf0;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter_if #(.AW(10), .DW(32)) b4 ();
    dmem_arbiter_if #(.AW(10), .DW(32)) b0 ();

    dmem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(MW)) dut4 (
        .clk(clk), .rst(rst), .bus(b4), .conflict_cnt(conf4)
    );
    dmem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .conflict_cnt(conf0)
    );

    always #5 clk = ~clk;

    logic [31:0] ram4 [1024];
    logic [31:0] ram0 [1024];
    logic [31:0] ref_mem [1024];

    always @(posedge clk) begin
        if (b4.mem_w) ram4[b4.mem_addr] <= b4.mem_wdata;
        if (b4.mem_r) b4.mem_rdata <= ram4[b4.mem_addr];
        if (b0.mem_w) ram0[b0.mem_addr] <= b0.mem_wdata;
        if (b0.mem_r) b0.mem_rdata <= ram0[b0.mem_addr];
    end

    // reference model state for the MAX_WAIT=4 instance
    int          m_waited;
    int          m_conf;
    logic        m_rv_cpu, m_rv_dma;
    logic [31:0] m_rdata;
    logic        m_cpu_stalled, m_dma_pending;
    logic        obs_gnt, obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_waited = 0;
        m_conf = 0;
        m_rv_cpu = 1'b0;
        m_rv_dma = 1'b0;
        m_rdata = '0;
        m_cpu_stalled = 1'b0;
        m_dma_pending = 1'b0;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
        b4.cpu_req_r = r; b4.cpu_req_w = w; b4.cpu_addr = a; b4.cpu_wdata = d;
    endtask

    task automatic set_dma(input logic rq, input logic we, input logic [9:0] a, input logic [31:0] d);
        b4.dma_req = rq; b4.dma_we = we; b4.dma_addr = a; b4.dma_wdata = d;
    endtask

    // one cycle of the MAX_WAIT=4 instance: check at negedge, advance model at posedge
    task automatic cycle4();
        logic creq, dwin, cwin, exp_r, exp_w;
        @(negedge clk);
        creq  = b4.cpu_req_r | b4.cpu_req_w;
        dwin  = b4.dma_req && (!creq || m_waited >= MW);
        cwin  = creq && !dwin;
        exp_r = (cwin && b4.cpu_req_r && !b4.cpu_req_w) || (dwin && !b4.dma_we);
        exp_w = (cwin && b4.cpu_req_w) || (dwin && b4.dma_we);
        obs_gnt   = b4.dma_gnt;
        obs_stall = b4.cpu_stall;
        check("cpu_stall", 32'(b4.cpu_stall), 32'(creq && !cwin));
        check("dma_gnt", 32'(b4.dma_gnt), 32'(dwin));
        check("mem_r", 32'(b4.mem_r), 32'(exp_r));
        check("mem_w", 32'(b4.mem_w), 32'(exp_w));
        if (cwin || dwin)
            check("mem_addr", 32'(b4.mem_addr), 32'(cwin ? b4.cpu_addr : b4.dma_addr));
        if (exp_w)
            check("mem_wdata", b4.mem_wdata, cwin ? b4.cpu_wdata : b4.dma_wdata);
        check("cpu_rvalid", 32'(b4.cpu_rvalid), 32'(m_rv_cpu));
        check("dma_rvalid", 32'(b4.dma_rvalid), 32'(m_rv_dma));
        if (m_rv_cpu) check("cpu_rdata", b4.cpu_rdata, m_rdata);
        if (m_rv_dma) check("dma_rdata", b4.dma_rdata, m_rdata);
        check("conflict_cnt", 32'(conf4), 32'(m_conf));
        @(posedge clk);
        if (creq && b4.dma_req && m_conf < 65535) m_conf++;
        if (dwin || !b4.dma_req) m_waited = 0;
        else if (m_waited < MW) m_waited++;
        m_rv_cpu = cwin && b4.cpu_req_r && !b4.cpu_req_w;
        m_rv_dma = dwin && !b4.dma_we;
        if (exp_r) m_rdata = ref_mem[cwin ? b4.cpu_addr : b4.dma_addr];
        if (exp_w) ref_mem[cwin ? b4.cpu_addr : b4.dma_addr] = cwin ? b4.cpu_wdata : b4.dma_wdata;
        m_cpu_stalled = creq && !cwin;
        m_dma_pending = b4.dma_req && !dwin;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram4[i] = '0; ram0[i] = '0; ref_mem[i] = '0;
        end
        b4.mem_rdata = '0;
        b0.mem_rdata = '0;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0);
        b0.cpu_req_r = 1'b0; b0.cpu_req_w = 1'b0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
        b0.dma_req = 1'b0; b0.dma_we = 1'b0; b0.dma_addr = '0; b0.dma_wdata = '0;
        model_reset();

        // reset state, with requests pending to prove grants are held off
        repeat (2) @(posedge clk);
        set_cpu(1'b1, 1'b0, 10'h001, '0);
        set_dma(1'b1, 1'b0, 10'h002, '0);
        @(negedge clk);
        check("rst_stall", 32'(b4.cpu_stall), 32'd0);
        check("rst_gnt", 32'(b4.dma_gnt), 32'd0);
        check("rst_mem_r", 32'(b4.mem_r), 32'd0);
        check("rst_mem_w", 32'(b4.mem_w), 32'd0);
        check("rst_rvalid", 32'({b4.cpu_rvalid, b4.dma_rvalid}), 32'd0);
        check("rst_conflict", 32'(conf4), 32'd0);
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        cycle4();

        // CPU only: store then load
        set_cpu(1'b0, 1'b1, 10'h010, 32'hDEADBEEF); cycle4();
        set_cpu(1'b1, 1'b0, 10'h010, '0);           cycle4();
        check("cpu_ld_rvalid", 32'(b4.cpu_rvalid), 32'd1);
        check("cpu_ld_data", b4.cpu_rdata, 32'hDEADBEEF);
        set_cpu(1'b0, 1'b0, '0, '0);                cycle4();

        // DMA only: write then read the top word
        set_dma(1'b1, 1'b1, 10'h3FF, 32'h00000005); cycle4();
        set_dma(1'b1, 1'b0, 10'h3FF, '0);           cycle4();
        check("dma_rd_rvalid", 32'(b4.dma_rvalid), 32'd1);
        check("dma_rd_data", b4.dma_rdata, 32'h00000005);
        set_dma(1'b0, 1'b0, '0, '0);                cycle4();

        // contention: CPU loads every cycle, DMA holds a read
        set_dma(1'b1, 1'b0, 10'h3FF, '0);
        for (int c = 1; c <= 5; c++) begin
            if (!m_cpu_stalled) set_cpu(1'b1, 1'b0, 10'(c), '0);
            cycle4();
            check("contend_gnt", 32'(obs_gnt), 32'(c == 5));
            check("contend_stall", 32'(obs_stall), 32'(c == 5));
        end
        check("contend_conflict", 32'(conf4), 32'd5);
        check("contend_age_clr", 32'(dut4.age_cnt), 32'd0);
        check("contend_dma_rv", 32'(b4.dma_rvalid), 32'd1);
        set_dma(1'b0, 1'b0, '0, '0);
        cycle4();
        set_cpu(1'b0, 1'b0, '0, '0);
        cycle4();

        // simultaneous load+store acts as a store
        set_cpu(1'b1, 1'b1, 10'h020, 32'h12345678); cycle4();
        check("rw_no_rvalid", 32'(b4.cpu_rvalid), 32'd0);
        set_cpu(1'b0, 1'b0, '0, '0);                cycle4();
        set_cpu(1'b1, 1'b0, 10'h020, '0);           cycle4();
        check("rw_readback", b4.cpu_rdata, 32'h12345678);
        set_cpu(1'b0, 1'b0, '0, '0);                cycle4();

        // asynchronous reset mid-cycle drops an in-flight load response
        set_cpu(1'b1, 1'b0, 10'h010, '0);
        set_dma(1'b1, 1'b0, 10'h011, '0);
        cycle4();
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(b4.cpu_rvalid), 32'd0);
        check("arst_stall", 32'(b4.cpu_stall), 32'd0);
        check("arst_gnt", 32'(b4.dma_gnt), 32'd0);
        check("arst_mem", 32'({b4.mem_r, b4.mem_w}), 32'd0);
        check("arst_conflict", 32'(conf4), 32'd0);
        @(posedge clk);
        #2;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        model_reset();
        cycle4();

        // randomized traffic obeying the hold rules
        for (int i = 0; i < 400; i++) begin
            if (!m_cpu_stalled)
                set_cpu(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                        10'($urandom_range(0, 15)), $urandom);
            if (!m_dma_pending)
                set_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        10'($urandom_range(0, 15)), $urandom);
            cycle4();
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0);
        cycle4();

        // MAX_WAIT=0: DMA always wins, conflict counter saturates
        b0.cpu_req_r = 1'b1; b0.cpu_addr = 10'h005;
        b0.dma_req = 1'b1; b0.dma_we = 1'b0; b0.dma_addr = 10'h007;
        for (int i = 0; i < 65545; i++) begin
            @(negedge clk);
            check("mw0_conflict", 32'(conf0), (i > 65535) ? 32'd65535 : 32'(i));
            if (i < 8 || (i % 1024) == 0) begin
                check("mw0_gnt", 32'(b0.dma_gnt), 32'd1);
                check("mw0_stall", 32'(b0.cpu_stall), 32'd1);
                check("mw0_mem", 32'({b0.mem_r, b0.mem_w}), 32'd2);
                check("mw0_addr", 32'(b0.mem_addr), 32'h007);
                check("mw0_cpu_rv", 32'(b0.cpu_rvalid), 32'd0);
                check("mw0_dma_rv", 32'(b0.dma_rvalid), 32'(i > 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
